serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle for the bit-serial add/subtract sequencer.
// master drives requests and observes results; slave is the sequencer side.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, op_sub, a, b, abort,
    input  ready, busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b, abort,
    output ready, busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer built around a single one-bit full adder.
// Operands are shifted LSB-first through FA; the carry is held in carry_q between bits.

// state   | meaning
// S_IDLE  | waiting for start, ready=1, results held
// S_RUN   | one operand bit per clock through FA, busy=1
// S_DONE  | one-cycle done pulse, start ignored

module FA (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, sum_q;
  logic             carry_q, msb_cin, c_out_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  FA u_fa (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  assign accept   = (state == S_IDLE) && bus.start;
  assign last_bit = (state == S_RUN) && !bus.abort && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort)        state_nxt = S_IDLE;
        else if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with op_sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      msb_cin <= 1'b0;
    end else if (accept) begin
      a_sr    <= bus.a;
      b_sr    <= bus.op_sub ? ~bus.b : bus.b;
      carry_q <= bus.op_sub;
      s_sr    <= '0;
      cnt     <= '0;
    end else if (state == S_RUN) begin
      s_sr    <= {fa_sum, s_sr[WIDTH-1:1]};
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry_q <= fa_cout;
      cnt     <= cnt + CW'(1);
      if (last_bit) begin
        sum_q   <= {fa_sum, s_sr[WIDTH-1:1]};
        c_out_q <= fa_cout;
        msb_cin <= carry_q;
      end
    end
  end

  assign bus.ready    = (state == S_IDLE);
  assign bus.busy     = (state == S_RUN);
  assign bus.done     = (state == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = msb_cin ^ c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: scoreboard of expected results,
// checked on each done pulse, plus ignored-start, async reset and abort cases.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, carry into MSB from the low WIDTH-1 bits.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    exp_t             r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
    low   = {1'b0, a[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + WIDTH'(sub);
    r.sum = full[WIDTH-1:0];
    r.c   = full[WIDTH];
    r.v   = low[WIDTH-1] ^ full[WIDTH];
    return r;
  endfunction

  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sub, input bit push);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = sub;
    @(posedge clk);
    if (push) sb.push_back(model(a, b, sub));
    #1;
    bus.start  = 1'b0;
    bus.a      = ~a;
    bus.b      = ~b;
    bus.op_sub = ~sub;
  endtask

  task automatic wait_done(input string tag, input bit inj);
    int   k = 0;
    bit   found = 0;
    exp_t e;
    for (int i = 0; i < WIDTH + 6 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1;
      else begin
        k++;
        if (k == 1) chk({tag, "_busy"}, bus.busy, 1);
        if (inj && k == 3) begin
          bus.start = 1'b1;
          bus.a     = '1;
          bus.b     = '1;
        end else if (inj && k == 4) begin
          chk({tag, "_ready_in_run"}, bus.ready, 0);
          bus.start = 1'b0;
        end
      end
    end
    if (!found) begin
      chk({tag, "_done_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, k, WIDTH);
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, bus.sum, e.sum);
      chk({tag, "_c_out"}, bus.c_out, e.c);
      chk({tag, "_overflow"}, bus.overflow, e.v);
    end
    if (inj) begin
      chk({tag, "_ready_in_done"}, bus.ready, 0);
      bus.start = 1'b1;
      bus.a     = '1;
      bus.b     = '1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_ready_after"}, bus.ready, 1);
    if (inj) begin
      @(negedge clk);
      chk({tag, "_no_restart"}, bus.busy, 0);
      chk({tag, "_sum_held"}, bus.sum, e.sum);
    end
  endtask

  task automatic no_done_for(input int n, input string tag);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.abort  = 1'b0;
    #3;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_c_out", bus.c_out, 0);
    chk("rst_overflow", bus.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    accept_op(8'h5A, 8'h3C, 1'b0, 1); wait_done("add_ovf", 0);
    accept_op(8'hFF, 8'h01, 1'b0, 1); wait_done("add_wrap", 0);
    accept_op(8'h00, 8'h00, 1'b0, 1); wait_done("add_zero", 0);
    accept_op(8'h10, 8'h20, 1'b1, 1); wait_done("sub_neg", 0);
    accept_op(8'h80, 8'h01, 1'b1, 1); wait_done("sub_ovf", 0);
    accept_op(8'hA7, 8'h5B, 1'b0, 1); wait_done("add_mix", 0);
    accept_op(8'h33, 8'h33, 1'b1, 1); wait_done("sub_eq", 0);

    accept_op(8'h12, 8'h34, 1'b0, 1); wait_done("ign_start", 1);
    no_done_for(WIDTH + 2, "ign_start_single_done");

    // Async reset in RUN: drop mid-cycle, release a half-cycle later.
    accept_op(8'h5A, 8'h3C, 1'b0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_sum", bus.sum, 0);
    chk("arst_c_out", bus.c_out, 0);
    chk("arst_overflow", bus.overflow, 0);
    #4 rst_n = 1'b1;
    no_done_for(WIDTH + 4, "arst_no_done");
    accept_op(8'h01, 8'h01, 1'b0, 1); wait_done("after_rst", 0);

    accept_op(8'h05, 8'h03, 1'b0, 1); wait_done("pre_abort", 0);
    accept_op(8'h7F, 8'h01, 1'b0, 0);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    no_done_for(WIDTH + 2, "abort_no_done");
    chk("abort_sum", bus.sum, 8'h08);
    chk("abort_c_out", bus.c_out, 0);
    chk("abort_overflow", bus.overflow, 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
